// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: register map, bit positions, FSM encoding and divisor floor shared by the SD DOUT receiver.
package sd_spi_pkg;
    localparam logic [1:0] ADDR_RXDATA  = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_DIV     = 2'd3;
    localparam int ST_RRDY  = 0;
    localparam int ST_BUSY  = 1;
    localparam int ST_ROE   = 2;
    localparam int CT_START = 0;
    localparam int CT_IEN   = 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [7:0] DIV_MIN = 8'd2;
    function automatic logic [7:0] half_period(input logic [7:0] div);
        return (div < DIV_MIN) ? DIV_MIN : div;
    endfunction
endpackage

// File: rtl/sd_dout_rx_if.sv
// sd_dout_rx_if: Avalon-MM slave bus of the SD DOUT receiver.
interface sd_dout_rx_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master(output address, chipselect, read_n, write_n, writedata, input readdata);
    modport slave(input address, chipselect, read_n, write_n, writedata, output readdata);
endinterface

// File: rtl/sd_sync_bit.sv
// sd_sync_bit: multi-flop synchronizer bringing the asynchronous card DOUT into the clk domain.
module sd_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync <= '0;
        else sync <= {sync[STAGES-2:0], d};
    end
    assign q = sync[STAGES-1];
endmodule

// File: rtl/sd_dout_rx.sv
// sd_dout_rx: Avalon-MM SPI mode-0 byte receiver for the SD card DOUT line.
// START clocks out 8 sd_clk pulses and samples DOUT MSB-first into RXDATA.
module sd_dout_rx
    import sd_spi_pkg::*;
#(
    parameter logic [7:0] DIV_DEFAULT = 8'd63,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    sd_dout_rx_if.slave bus,
    input  logic        sd_dout,
    output logic        sd_clk,
    output logic        irq
);
    logic [1:0] state;
    logic [7:0] cnt, h, div, shift, rxdata;
    logic [2:0] bit_cnt;
    logic       rrdy, roe, ien, din_s;
    logic       wr, rd_data, start, busy, half_end, done;
    logic       unused_ok;

    sd_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .reset_n(reset_n), .d(sd_dout), .q(din_s)
    );

    assign wr       = bus.chipselect & ~bus.write_n;
    assign rd_data  = bus.chipselect & ~bus.read_n & (bus.address == ADDR_RXDATA);
    assign busy     = state != S_IDLE;
    assign start    = wr & (bus.address == ADDR_CONTROL) & bus.writedata[CT_START] & ~busy;
    assign half_end = cnt == h - 8'd1;
    assign done     = state == S_DONE;
    assign irq      = rrdy & ien;
    assign unused_ok = &{1'b0, bus.writedata[31:8]};

    // Divisor is captured at START so DIV writes mid-byte only affect the next byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            h       <= DIV_MIN;
            bit_cnt <= '0;
            shift   <= '0;
            sd_clk  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state   <= S_LOW;
                    cnt     <= '0;
                    bit_cnt <= '0;
                    h       <= half_period(div);
                end
                S_LOW: if (half_end) begin
                    state  <= S_HIGH;
                    cnt    <= '0;
                    sd_clk <= 1'b1;
                end else cnt <= cnt + 8'd1;
                S_HIGH: if (half_end) begin
                    shift   <= {shift[6:0], din_s};
                    sd_clk  <= 1'b0;
                    cnt     <= '0;
                    bit_cnt <= bit_cnt + 3'd1;
                    state   <= (bit_cnt == 3'd7) ? S_DONE : S_LOW;
                end else cnt <= cnt + 8'd1;
                default: state <= S_IDLE;
            endcase
        end
    end

    // A byte landing in the same cycle as an RXDATA read keeps RRDY set; overrun set beats clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxdata <= '0;
            rrdy   <= 1'b0;
            roe    <= 1'b0;
            ien    <= 1'b0;
            div    <= DIV_DEFAULT;
        end else begin
            if (done) rxdata <= shift;
            rrdy <= done ? 1'b1 : rd_data ? 1'b0 : rrdy;
            roe  <= (done & rrdy & ~rd_data) ? 1'b1
                  : (wr & (bus.address == ADDR_STATUS) & bus.writedata[ST_ROE]) ? 1'b0 : roe;
            if (wr & (bus.address == ADDR_CONTROL)) ien <= bus.writedata[CT_IEN];
            if (wr & (bus.address == ADDR_DIV)) div <= bus.writedata[7:0];
        end
    end

    assign bus.readdata = (bus.address == ADDR_RXDATA)  ? {24'd0, rxdata}
                        : (bus.address == ADDR_STATUS)  ? {29'd0, roe, busy, rrdy}
                        : (bus.address == ADDR_CONTROL) ? {30'd0, ien, 1'b0}
                        : {24'd0, div};
endmodule

// File: tb/tb_sd_dout_rx.sv
// tb_sd_dout_rx: directed bench with a cycle-timed register/pulse model and an SD card DOUT model.
module tb_sd_dout_rx;
    logic clk = 1'b0, reset_n = 1'b0, sd_dout = 1'b0;
    logic sd_clk, irq;
    sd_dout_rx_if bus();

    sd_dout_rx #(.DIV_DEFAULT(8'd63), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .sd_dout(sd_dout), .sd_clk(sd_clk), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    int last_t = 0, t_start = 0, pulses = 0, hi_len = 0, lo_len = 0, run = 0;
    logic prev_clk = 1'b0, ien_sh = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Card: presents the MSB before START and the next bit after each sd_clk fall.
    logic [7:0] tx = 8'h00;
    int idx = 0;
    always @(negedge sd_clk) begin
        idx++;
        sd_dout = (idx < 8) ? tx[7-idx] : 1'b0;
    end

    // Model: byte occupies cycles T+1..T+16H with sd_clk high in odd half periods, DONE at T+1+16H.
    logic [7:0] m_div = 8'd63, m_rx = 8'd0, m_byte = 8'd0;
    logic m_rrdy = 1'b0, m_roe = 1'b0, m_ien = 1'b0, m_act = 1'b0;
    int m_t = 0, m_h = 2;
    logic w_en, r0, dn, st, clr, setr;

    function automatic logic m_busy(input int c);
        return m_act && c > m_t;
    endfunction
    function automatic logic m_sclk(input int c);
        int k;
        k = c - m_t - 1;
        return m_act && k >= 0 && k < 16 * m_h && (k / m_h) % 2 == 1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_div = 8'd63; m_rx = 8'd0; m_rrdy = 1'b0; m_roe = 1'b0; m_ien = 1'b0; m_act = 1'b0;
        end else begin
            w_en = bus.chipselect && !bus.write_n;
            r0   = bus.chipselect && !bus.read_n && bus.address == 2'd0;
            dn   = m_act && cyc == m_t + 1 + 16 * m_h;
            st   = w_en && bus.address == 2'd2 && bus.writedata[0] && !m_act;
            clr  = w_en && bus.address == 2'd1 && bus.writedata[2];
            setr = dn && m_rrdy && !r0;
            m_roe  = setr ? 1'b1 : clr ? 1'b0 : m_roe;
            m_rrdy = dn ? 1'b1 : r0 ? 1'b0 : m_rrdy;
            if (dn) begin m_rx = m_byte; m_act = 1'b0; end
            if (w_en && bus.address == 2'd2) m_ien = bus.writedata[1];
            if (st) begin m_act = 1'b1; m_t = cyc; m_h = (m_div < 8'd2) ? 2 : int'(m_div); m_byte = tx; end
            if (w_en && bus.address == 2'd3) m_div = bus.writedata[7:0];
            cyc++;
        end
    end

    logic [31:0] e_rd;
    always @(negedge clk) begin
        e_rd = (bus.address == 2'd0) ? {24'd0, m_rx}
             : (bus.address == 2'd1) ? {29'd0, m_roe, m_busy(cyc), m_rrdy}
             : (bus.address == 2'd2) ? {30'd0, m_ien, 1'b0} : {24'd0, m_div};
        chk("readdata", bus.readdata, e_rd);
        chk("sd_clk", {31'd0, sd_clk}, {31'd0, m_sclk(cyc)});
        chk("irq", {31'd0, irq}, {31'd0, m_rrdy & m_ien});
        if (sd_clk !== prev_clk) begin
            if (sd_clk) begin pulses++; lo_len = run; end
            else hi_len = run;
            run = 1;
        end else run++;
        prev_clk = sd_clk;
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d; last_t = cyc;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        bus.address = a; bus.chipselect = 1'b1; bus.read_n = 1'b0;
        #2 d = bus.readdata;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.read_n = 1'b1;
    endtask

    task automatic peek(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        bus.address = a;
        #2 d = bus.readdata;
    endtask

    task automatic rx_start(input logic [7:0] b);
        tx = b; idx = 0; sd_dout = b[7]; pulses = 0;
        bus_write(2'd2, {30'd0, ien_sh, 1'b1});
        t_start = last_t;
    endtask

    task automatic rx_wait(input int h);
        int n;
        n = 0;
        bus.address = 2'd1;
        #1;
        while (bus.readdata[1] && n < 16 * h + 50) begin @(negedge clk); n++; end
        if (n >= 16 * h + 50) chk("busy_timeout", 32'd1, 32'd0);
        chk("rrdy_latency", cyc - t_start, 2 + 16 * h);
        chk("rrdy_at_idle", {31'd0, bus.readdata[0]}, 32'd1);
        chk("pulse_count", pulses, 8);
        chk("high_len", hi_len, h);
        chk("low_len", lo_len, h);
    endtask

    logic [31:0] r;
    int n;
    initial begin
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.read_n = 1'b1; bus.write_n = 1'b1; bus.writedata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            peek(a[1:0], r);
            chk("reset_reg", r, (a == 3) ? 32'd63 : 32'd0);
        end
        chk("reset_sd_clk", {31'd0, sd_clk}, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);

        bus_write(2'd3, 32'd2);
        rx_start(8'hA5); rx_wait(2);
        peek(2'd0, r); chk("rx_a5", r, 32'hA5);
        bus_read(2'd0, r);
        peek(2'd1, r); chk("rrdy_cleared", r, 32'h0);

        rx_start(8'h3C); rx_wait(2);
        rx_start(8'hC3); rx_wait(2);
        peek(2'd1, r); chk("overrun_status", r, 32'h5);
        peek(2'd0, r); chk("rx_c3", r, 32'hC3);
        bus_write(2'd1, 32'h4);
        peek(2'd1, r); chk("roe_cleared", r, 32'h1);
        bus_read(2'd0, r);

        bus_write(2'd3, 32'd0); rx_start(8'h69); rx_wait(2); bus_read(2'd0, r); chk("rx_69", r, 32'h69);
        bus_write(2'd3, 32'd1); rx_start(8'h96); rx_wait(2); bus_read(2'd0, r); chk("rx_96", r, 32'h96);
        bus_write(2'd3, 32'd5); rx_start(8'h3B);
        repeat (3) @(posedge clk);
        bus_write(2'd2, 32'd1);
        rx_wait(5); bus_read(2'd0, r); chk("rx_3b", r, 32'h3B);

        ien_sh = 1'b1;
        bus_write(2'd2, 32'd2); bus_write(2'd3, 32'd2);
        rx_start(8'hFF); rx_wait(2);
        chk("irq_set", {31'd0, irq}, 32'd1);
        bus_read(2'd0, r); chk("rx_ff", r, 32'hFF);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        ien_sh = 1'b0;
        bus_write(2'd2, 32'd0);

        rx_start(8'h96); rx_wait(2);
        rx_start(8'h5A);
        n = 0;
        while (cyc < t_start + 1 + 32 && n < 100) begin @(posedge clk); #1; n++; end
        chk("done_cycle_reached", cyc, t_start + 33);
        bus.address = 2'd0; bus.chipselect = 1'b1; bus.read_n = 1'b0;
        #2 r = bus.readdata;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.read_n = 1'b1;
        chk("done_read_old", r, 32'h96);
        peek(2'd1, r); chk("done_read_status", r, 32'h1);
        peek(2'd0, r); chk("rx_5a", r, 32'h5A);

        bus_write(2'd3, 32'd3);
        rx_start(8'h77);
        n = 0;
        while (pulses < 4 && n < 200) begin @(negedge clk); n++; end
        chk("fourth_rise", pulses, 4);
        #2 chk("pre_reset_sd_clk", {31'd0, sd_clk}, 32'd1);
        reset_n = 1'b0;
        #1 chk("async_sd_clk", {31'd0, sd_clk}, 32'd0);
        peek(2'd1, r); chk("reset_status", r, 32'h0);
        peek(2'd0, r); chk("reset_rxdata", r, 32'h0);
        @(negedge clk); reset_n = 1'b1;
        rx_start(8'h81); rx_wait(63);
        peek(2'd0, r); chk("rx_81", r, 32'h81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
